// File: rtl/wb_la_initiator_pkg.sv
// Shared types and defaults for the Wishbone logic-analyzer initiator.
package wb_la_initiator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating REQ-phase counter; flags expiry on the last permitted wait cycle.
module wb_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == CntW'(LIMIT - 1));

endmodule

// File: rtl/wb_la_initiator.sv
// Single-outstanding Wishbone classic initiator behind a cmd/rsp handshake.
// Optional ack timeout enabled by defining WB_LA_INITIATOR_TIMEOUT_EN.
module wb_la_initiator
  import wb_la_initiator_pkg::*;
#(
  parameter int unsigned ADR_W   = 32,
  parameter int unsigned DAT_W   = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [DAT_W/8-1:0] cmd_sel,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [DAT_W-1:0]   wbm_dat_i
);

  state_e r_state, w_state_next;

  logic               r_cyc;
  logic               r_we;
  logic [DAT_W/8-1:0] r_sel;
  logic [ADR_W-1:0]   r_adr;
  logic [DAT_W-1:0]   r_wdata;
  logic               r_rsp_valid;
  logic [DAT_W-1:0]   r_rdata;
  logic               w_accept;
  logic               w_req;
  logic               w_timeout;

  assign cmd_ready = (r_state == StIdle) && !wb_rst_i;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_req     = (r_state == StReq);

`ifdef WB_LA_INITIATOR_TIMEOUT_EN
  logic r_err;
  logic w_expired;

  wb_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_clr     (w_accept),
    .i_en      (w_req && !wbm_ack_i),
    .o_expired (w_expired)
  );

  assign w_timeout = w_req && w_expired;
  assign rsp_err   = r_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StReq;
      StReq:   if (wbm_ack_i || w_timeout) w_state_next = StResp;
      StResp:  if (rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Bus attributes stay at their last values once the cycle ends; only cyc/stb drop.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
`ifdef WB_LA_INITIATOR_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_cyc   <= 1'b1;
            r_we    <= cmd_we;
            r_sel   <= cmd_sel;
            r_adr   <= cmd_adr;
            r_wdata <= cmd_wdata;
          end
        end
        StReq: begin
          // Ack takes priority over a timeout expiring on the same edge.
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_rdata     <= r_we ? '0 : wbm_dat_i;
            r_rsp_valid <= 1'b1;
`ifdef WB_LA_INITIATOR_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b1;
`ifdef WB_LA_INITIATOR_TIMEOUT_EN
            r_err       <= 1'b1;
`endif
          end
        end
        StResp: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_wdata;

endmodule

// File: tb/tb_wb_la_initiator.sv
// Randomized scoreboard bench for wb_la_initiator: a driver, a Wishbone slave model
// and a response monitor run as separate processes sharing plan/expectation queues.
module tb_wb_la_initiator;

  localparam int unsigned TMO = 8;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdata;
    int          waits;  // -1: slave never acks
    logic [31:0] data;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  plan_t plan_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    stray_cnt = 0;
  int    bp_mode = 0;  // 0 random ready, 1 hold low, 2 hold high

  always #5 wb_clk_i = ~wb_clk_i;

  wb_la_initiator #(
    .ADR_W   (32),
    .DAT_W   (32),
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_sel   (cmd_sel),
    .cmd_adr   (cmd_adr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic plan_t mk(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                               input logic [31:0] wd, input int waits, input logic [31:0] data);
    plan_t p;
    p.we = we; p.sel = sel; p.adr = adr; p.wdata = wd; p.waits = waits; p.data = data;
    return p;
  endfunction

  function automatic exp_t rsp_of(input plan_t p);
    exp_t e;
    e.err   = (p.waits < 0);
    e.rdata = (p.we || p.waits < 0) ? 32'h0 : p.data;
    return e;
  endfunction

  task automatic present(input plan_t p);
    cmd_we    = p.we;
    cmd_sel   = p.sel;
    cmd_adr   = p.adr;
    cmd_wdata = p.wdata;
    cmd_valid = 1'b1;
  endtask

  // Called at a falling edge with the command already presented.
  task automatic accept(input plan_t p, input bit has_rsp);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 100) begin
      chk("cmd_accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    plan_q.push_back(p);
    if (has_rsp) sb_q.push_back(rsp_of(p));
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_sel   = 4'($urandom);
    cmd_adr   = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic send(input plan_t p, input bit has_rsp);
    @(negedge wb_clk_i);
    present(p);
    accept(p, has_rsp);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || rsp_valid) && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 300) chk("drain_timeout", sb_q.size(), 0);
  endtask

  // Response ready generator.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      #1;
      case (bp_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Wishbone slave model: follows the plan queue, checks bus contents and cycle length.
  initial begin
    plan_t p;
    bit    busy = 0;
    bit    acked = 0;
    int    wcnt = 0;
    int    ccyc = 0;
    int    seen = 0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge wb_clk_i);
      #1;
      wbm_ack_i = 1'b0;
      wbm_dat_i = $urandom;
      if (wb_rst_i) begin
        busy  = 0;
        acked = 0;
        continue;
      end
      if (acked) begin
        chk("cyc_drop_after_ack", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("cyc_len", ccyc, p.waits + 1);
        acked = 0;
        busy  = 0;
      end
      if (busy && !wbm_cyc_o) begin
`ifdef WB_LA_INITIATOR_TIMEOUT_EN
        chk("timeout_len", ccyc, TMO);
`else
        chk("cyc_dropped_without_ack", wbm_cyc_o, 1);
`endif
        busy = 0;
      end
      if (!busy && wbm_cyc_o) begin
        if (plan_q.size() == 0) begin
          chk("cyc_unexpected", wbm_cyc_o, 0);
        end else begin
          p    = plan_q.pop_front();
          busy = 1;
          wcnt = 0;
          ccyc = 0;
        end
      end
      if (busy) begin
        ccyc++;
        chk("wb_bus", {wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
            {1'b1, p.we, p.sel, p.adr, p.wdata});
        if (p.waits >= 0 && wcnt == p.waits) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = p.data;
          acked     = 1;
        end
        wcnt++;
      end else if (!wbm_cyc_o && seen != stray_cnt) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = $urandom;
        seen++;
      end
    end
  end

  // Response monitor: pops the scoreboard on every handshake, checks stability while stalled.
  initial begin
    exp_t        e;
    bit          hold_v = 0;
    logic [31:0] hold_rd = '0;
    logic        hold_err = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      #2;
      if (wb_rst_i) begin
        hold_v = 0;
        continue;
      end
      if (rsp_valid) begin
        if (hold_v) chk("rsp_stable", {rsp_rdata, rsp_err}, {hold_rd, hold_err});
        if (rsp_ready) begin
          if (sb_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 0);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
          end
          hold_v = 0;
        end else begin
          hold_v   = 1;
          hold_rd  = rsp_rdata;
          hold_err = rsp_err;
        end
      end else begin
        hold_v = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Driver.
  initial begin
    plan_t p;
    plan_t q;
    int    n;
    int    bad;
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = '0;
    cmd_adr   = '0;
    cmd_wdata = '0;

    repeat (3) @(negedge wb_clk_i);
    chk("cmd_ready_in_reset", cmd_ready, 0);
    chk("reset_outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                          rsp_valid, rsp_err, rsp_rdata}, 0);
    wb_rst_i = 1'b0;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);

    // Directed write, ack in the first strobe cycle.
    bp_mode = 2;
    p = mk(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_1234, 0, $urandom);
    send(p, 1);
    drain();
    chk("attrs_held", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
        {1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_1234});

    // Directed read with three wait states.
    p = mk(1'b0, 4'hF, 32'h30FF_FFF8, 32'h0, 3, 32'hCAFE_F00D);
    send(p, 1);
    drain();

    // Backpressure: response stalls, next command must wait for the handshake.
    bp_mode = 1;
    p = mk(1'b0, 4'h3, $urandom, $urandom, 2, $urandom);
    send(p, 1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    q = mk(1'b1, 4'hC, $urandom, $urandom, 1, $urandom);
    present(q);
    bad = 0;
    repeat (10) begin
      @(negedge wb_clk_i);
      if (cmd_ready || wbm_cyc_o) bad++;
    end
    chk("bp_no_accept", bad, 0);
    bp_mode = 2;
    chk("cmd_ready_before_hs", cmd_ready, 0);
    @(negedge wb_clk_i);
    chk("cmd_ready_after_hs", cmd_ready, 1);
    accept(q, 1);
    drain();

    // No ack at all.
`ifdef WB_LA_INITIATOR_TIMEOUT_EN
    p = mk(1'b0, 4'hF, $urandom, $urandom, -1, $urandom);
    send(p, 1);
    drain();
    chk("timeout_idle", {wbm_cyc_o, cmd_ready}, 2'b01);
`else
    p = mk(1'b0, 4'hF, $urandom, $urandom, -1, $urandom);
    send(p, 0);
    bad = 0;
    repeat (1000) begin
      @(negedge wb_clk_i);
      if (!wbm_cyc_o || !wbm_stb_o || rsp_valid) bad++;
    end
    chk("cyc_held_1000", bad, 0);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
`endif

    // Reset in the middle of a request, then a stray ack.
    p = mk(1'b0, 4'hF, $urandom, $urandom, -1, $urandom);
    send(p, 0);
    repeat (3) @(negedge wb_clk_i);
    chk("req_active", wbm_cyc_o, 1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("mid_req_reset", {wbm_cyc_o, wbm_stb_o, rsp_valid}, 0);
    wb_rst_i = 1'b0;
    stray_cnt++;
    repeat (4) @(negedge wb_clk_i);
    chk("stray_after_reset", {wbm_cyc_o, rsp_valid, cmd_ready}, 3'b001);

    // Spurious ack in IDLE, then in RESP with the response stalled.
    stray_cnt++;
    repeat (3) @(negedge wb_clk_i);
    chk("stray_in_idle", {wbm_cyc_o, rsp_valid, cmd_ready}, 3'b001);
    bp_mode = 1;
    p = mk(1'b0, 4'hF, $urandom, $urandom, 1, $urandom);
    send(p, 1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    stray_cnt++;
    repeat (3) @(negedge wb_clk_i);
    chk("stray_in_resp_rdata", rsp_rdata, p.data);
    bp_mode = 2;
    drain();

    // Randomized traffic.
    bp_mode = 0;
    for (int i = 0; i < 60; i++) begin
      p = mk(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom_range(0, 4), $urandom);
      send(p, 1);
      if ($urandom_range(0, 2) == 0) stray_cnt++;
      if ($urandom_range(0, 3) != 0) drain();
    end
    drain();
    repeat (5) @(negedge wb_clk_i);
    chk("end_idle", {wbm_cyc_o, rsp_valid, plan_q.size() == 0}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
